// File: rtl/sdram_pkg.sv
// Shared SDRAM init definitions: command encodings, FSM states, bus widths.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 13;
    localparam int SDRAM_BA_W   = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    typedef enum logic [3:0] {
        WAIT_LOCK,
        PWRUP,
        PRECHARGE,
        WAIT_RP,
        REFRESH,
        WAIT_RFC,
        LOAD_MODE,
        WAIT_MRD,
        DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_powerup_seq_lock_filter.sv
// PLL lock synchronizer plus stability filter: stable rises once the
// synchronized lock has been high for LOCK_STABLE consecutive cycles.
module lock_filter #(
    parameter int LOCK_STABLE = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic stable
);

    localparam int CNT_W = $clog2(LOCK_STABLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_STABLE);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
            // a single low cycle restarts the stability window
            if (!sync_p1)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign stable = (cnt == CNT_MAX);

endmodule

// File: rtl/sdram_powerup_seq.sv
// SDRAM power-up sequencer: lock wait, power-up NOP, precharge-all, N refreshes,
// mode load. Define SDRAM_LOCK_WATCH_EN to make lock loss in DONE restart the sequence.
module sdram_powerup_seq
    import sdram_pkg::*;
#(
    parameter int                       CLK_MHZ     = 100,
    parameter int                       PWRUP_US    = 200,
    parameter int                       LOCK_STABLE = 1024,
    parameter int                       T_RP        = 3,
    parameter int                       T_RFC       = 7,
    parameter int                       T_MRD       = 2,
    parameter int                       N_REFRESH   = 2,
    parameter logic [SDRAM_ADDR_W-1:0]  MODE_REG    = 13'h0030
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pll_locked,
    output logic                    sdram_cke,
    output logic                    sdram_cs_n,
    output logic                    sdram_ras_n,
    output logic                    sdram_cas_n,
    output logic                    sdram_we_n,
    output logic [SDRAM_BA_W-1:0]   sdram_ba,
    output logic [SDRAM_ADDR_W-1:0] sdram_addr,
    output logic                    init_done,
    output logic                    sys_rst
);

    localparam int PWRUP_CYC = CLK_MHZ * PWRUP_US;
    localparam int MAX_DLY   = max_int(max_int(PWRUP_CYC, T_RP), max_int(T_RFC, T_MRD));
    localparam int DLY_W     = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
    localparam int REF_W     = (N_REFRESH > 0) ? $clog2(N_REFRESH + 1) : 1;

    // Wait states exit at T-2: the command cycle and the exit edge account for the rest.
    // T_RP, T_RFC and T_MRD must therefore be at least 2.
    localparam logic [DLY_W-1:0] PWRUP_END = DLY_W'(PWRUP_CYC - 1);
    localparam logic [DLY_W-1:0] RP_END    = DLY_W'(T_RP - 2);
    localparam logic [DLY_W-1:0] RFC_END   = DLY_W'(T_RFC - 2);
    localparam logic [DLY_W-1:0] MRD_END   = DLY_W'(T_MRD - 2);
    localparam logic [DLY_W-1:0] DLY_SAT   = '1;
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(N_REFRESH);
    localparam logic [SDRAM_ADDR_W-1:0] PRECHARGE_ALL = 13'h0400;

    state_t           state;
    logic [3:0]       cmd;
    logic [DLY_W-1:0] dly;
    logic [DLY_W-1:0] dly_inc;
    logic [REF_W-1:0] ref_cnt;
    logic [REF_W-1:0] ref_inc;
    logic             lock_ok;

    lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clk      (clk),
        .rst      (rst),
        .async_in (pll_locked),
        .stable   (lock_ok)
    );

    assign dly_inc = (dly == DLY_SAT) ? dly : dly + 1'b1;
    assign ref_inc = (ref_cnt == REF_LAST) ? ref_cnt : ref_cnt + 1'b1;

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            sdram_cke  <= 1'b0;
            cmd        <= CMD_NOP;
            sdram_ba   <= '0;
            sdram_addr <= '0;
            dly        <= '0;
            ref_cnt    <= '0;
            init_done  <= 1'b0;
            sys_rst    <= 1'b1;
        end else begin
            // command bus idles as NOP with zero address unless a command is issued below
            cmd        <= CMD_NOP;
            sdram_ba   <= '0;
            sdram_addr <= '0;
            if (!lock_ok && state != WAIT_LOCK && state != DONE) begin
                state     <= WAIT_LOCK;
                sdram_cke <= 1'b0;
                dly       <= '0;
                ref_cnt   <= '0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        sdram_cke <= 1'b0;
                        dly       <= '0;
                        ref_cnt   <= '0;
                        if (lock_ok) begin
                            state     <= PWRUP;
                            sdram_cke <= 1'b1;
                        end
                    end
                    PWRUP: begin
                        if (dly == PWRUP_END) begin
                            state      <= PRECHARGE;
                            cmd        <= CMD_PRECHARGE;
                            sdram_addr <= PRECHARGE_ALL;
                            dly        <= '0;
                        end else begin
                            dly <= dly_inc;
                        end
                    end
                    PRECHARGE: state <= WAIT_RP;
                    WAIT_RP: begin
                        if (dly == RP_END) begin
                            state <= REFRESH;
                            cmd   <= CMD_REFRESH;
                            dly   <= '0;
                        end else begin
                            dly <= dly_inc;
                        end
                    end
                    REFRESH: begin
                        state   <= WAIT_RFC;
                        ref_cnt <= ref_inc;
                    end
                    WAIT_RFC: begin
                        if (dly == RFC_END) begin
                            dly <= '0;
                            if (ref_cnt == REF_LAST) begin
                                state      <= LOAD_MODE;
                                cmd        <= CMD_LOAD_MODE;
                                sdram_addr <= MODE_REG;
                            end else begin
                                state <= REFRESH;
                                cmd   <= CMD_REFRESH;
                            end
                        end else begin
                            dly <= dly_inc;
                        end
                    end
                    LOAD_MODE: state <= WAIT_MRD;
                    WAIT_MRD: begin
                        if (dly == MRD_END) begin
                            state     <= DONE;
                            init_done <= 1'b1;
                            sys_rst   <= 1'b0;
                            dly       <= '0;
                        end else begin
                            dly <= dly_inc;
                        end
                    end
                    DONE: begin
`ifdef SDRAM_LOCK_WATCH_EN
                        if (!lock_ok) begin
                            state     <= WAIT_LOCK;
                            sdram_cke <= 1'b0;
                            init_done <= 1'b0;
                            sys_rst   <= 1'b1;
                        end
`else
                        state <= DONE;
`endif
                    end
                    default: state <= WAIT_LOCK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_powerup_seq.sv
// Bench for sdram_powerup_seq: timeline reference model checked every cycle,
// directed scenarios with literal timings, and randomized lock/reset stimulus.
module tb_sdram_powerup_seq;

    localparam int CLK_MHZ     = 100;
    localparam int PWRUP_US    = 1;
    localparam int LOCK_STABLE = 16;
    localparam int T_RP        = 3;
    localparam int T_RFC       = 7;
    localparam int T_MRD       = 2;
    localparam int N_REFRESH   = 2;
    localparam logic [12:0] MODE_REG = 13'h0030;

    // offsets measured from the edge the sequence leaves the lock wait
    localparam int OFF_PRE  = CLK_MHZ * PWRUP_US;
    localparam int OFF_LOAD = OFF_PRE + T_RP + N_REFRESH * T_RFC;
    localparam int OFF_DONE = OFF_LOAD + T_MRD;
    // lock must have been sampled high on the LOCK_STABLE edges ending 3 edges back
    localparam int HIST_N   = LOCK_STABLE + 2;

    logic        clk;
    logic        rst;
    logic        pll_locked;
    logic        sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic        init_done;
    logic        sys_rst;

    int errors = 0;
    int checks = 0;

    sdram_powerup_seq #(
        .CLK_MHZ     (CLK_MHZ),
        .PWRUP_US    (PWRUP_US),
        .LOCK_STABLE (LOCK_STABLE),
        .T_RP        (T_RP),
        .T_RFC       (T_RFC),
        .T_MRD       (T_MRD),
        .N_REFRESH   (N_REFRESH),
        .MODE_REG    (MODE_REG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .sdram_cke   (sdram_cke),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_ba    (sdram_ba),
        .sdram_addr  (sdram_addr),
        .init_done   (init_done),
        .sys_rst     (sys_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] cmd_now();
        return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    endfunction

    // ---------------- reference model ----------------
    bit hist [HIST_N];
    int mode = 0;             // 0 waiting for lock, 1 sequencing, 2 done
    int k = 0;
    bit model_valid = 1'b0;

    function automatic bit lock_ok_now();
        for (int i = 2; i < HIST_N; i++)
            if (!hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_cmd(input int off);
        if (off == OFF_PRE) return 4'b0010;
        for (int i = 0; i < N_REFRESH; i++)
            if (off == OFF_PRE + T_RP + i * T_RFC) return 4'b0001;
        if (off == OFF_LOAD) return 4'b0000;
        return 4'b0111;
    endfunction

    function automatic logic [21:0] exp_outputs();
        logic [3:0]  c;
        logic [12:0] a;
        if (mode == 0) return {1'b0, 4'b0111, 2'b00, 13'h0, 1'b0, 1'b1};
        if (mode == 2) return {1'b1, 4'b0111, 2'b00, 13'h0, 1'b1, 1'b0};
        c = exp_cmd(k);
        a = (c == 4'b0010) ? 13'h0400 : (c == 4'b0000) ? MODE_REG : 13'h0;
        return {1'b1, c, 2'b00, a, 1'b0, 1'b1};
    endfunction

    initial begin
        bit lk;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < HIST_N; i++) hist[i] = 1'b0;
                mode = 0;
                k = 0;
                model_valid = 1'b1;
            end else begin
                lk = lock_ok_now();
                case (mode)
                    0: if (lk) begin mode = 1; k = 0; end
                    1: begin
                        if (!lk) mode = 0;
                        else begin
                            k++;
                            if (k == OFF_DONE) mode = 2;
                        end
                    end
                    default: begin
`ifdef SDRAM_LOCK_WATCH_EN
                        if (!lk) mode = 0;
`endif
                    end
                endcase
            end
            for (int i = HIST_N - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = rst ? 1'b0 : pll_locked;
        end
    end

    initial begin
        logic [3:0] c;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                c = cmd_now();
                check("outputs_vs_model",
                      {sdram_cke, c, sdram_ba, sdram_addr, init_done, sys_rst}, exp_outputs());
                check("cmd_legal",
                      ((c == 4'b0111 || c == 4'b0010 || c == 4'b0001 || c == 4'b0000) &&
                       (sdram_cke || c == 4'b0111)) ? 1 : 0, 1);
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic run_s1(input string tag);
        int pre = -1, pre_a10 = -1, r1 = -1, r2 = -1, ld = -1, ld_addr = -1, dn = -1;
        logic [3:0] c;
        rst = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < 300 && dn < 0; i++) begin
            @(negedge clk);
            c = cmd_now();
            if (c == 4'b0010 && pre < 0) begin pre = i; pre_a10 = sdram_addr[10]; end
            if (c == 4'b0001) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            if (c == 4'b0000 && ld < 0) begin ld = i; ld_addr = sdram_addr; end
            if (init_done && dn < 0) dn = i;
        end
        check({tag, "_precharge_at"}, pre, 118);
        check({tag, "_precharge_a10"}, pre_a10, 1);
        check({tag, "_refresh1_at"}, r1, 121);
        check({tag, "_refresh2_at"}, r2, 128);
        check({tag, "_load_mode_at"}, ld, 135);
        check({tag, "_load_mode_addr"}, ld_addr, 32'h030);
        check({tag, "_init_done_at"}, dn, 137);
        check({tag, "_sys_rst_done"}, sys_rst, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_cke, seen_done, nref, saw_low, got, first_low, still;
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cke", sdram_cke, 0);
        check("reset_cmd", cmd_now(), 4'b0111);
        check("reset_addr_ba", {sdram_ba, sdram_addr}, 0);
        check("reset_init_done", init_done, 0);
        check("reset_sys_rst", sys_rst, 1);

        // S1: steady lock from reset release
        run_s1("s1");

        // S2: lock never stays high long enough
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_cke = 0;
        seen_done = 0;
        for (int c2 = 0; c2 < 120; c2++) begin
            pll_locked = ((c2 % 10) != 9);
            @(negedge clk);
            if (sdram_cke) seen_cke = 1;
            if (init_done) seen_done = 1;
        end
        check("s2_cke_stays_low", seen_cke, 0);
        check("s2_init_done_low", seen_done, 0);

        // S3: lock drop during WAIT_RFC
        pll_locked = 1'b1;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (cmd_now() == 4'b0001) got = 1;
        end
        check("s3_first_refresh_seen", got, 1);
        repeat (2) @(negedge clk);
        pll_locked = 1'b0;
        nref = 0;
        saw_low = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cmd_now() == 4'b0001) nref++;
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 400 && !init_done; i++) begin
            @(negedge clk);
            if (!sdram_cke) saw_low = 1;
            if (cmd_now() == 4'b0001) nref++;
        end
        check("s3_returned_to_wait_lock", saw_low, 1);
        check("s3_refresh_count", nref, 2);
        check("s3_init_done", init_done, 1);

        // S4: one-cycle reset in DONE
        rst = 1'b1;
        @(negedge clk);
        check("s4_init_done_cleared", init_done, 0);
        check("s4_sys_rst_raised", sys_rst, 1);
        run_s1("s4");

        // S5: lock loss in DONE
        pll_locked = 1'b0;
        first_low = -1;
        still = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!init_done) begin
                still = 0;
                if (first_low < 0) first_low = i;
            end
        end
`ifdef SDRAM_LOCK_WATCH_EN
        check("s5_init_done_drops", (first_low >= 0 && first_low <= 3) ? 1 : 0, 1);
        check("s5_sys_rst_raised", sys_rst, 1);
`else
        check("s5_init_done_holds", still, 1);
        check("s5_sys_rst_holds", sys_rst, 0);
`endif
        pll_locked = 1'b1;
        repeat (5) @(negedge clk);

        // randomized lock glitches and resets, checked by the model every cycle
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            if ($urandom_range(0, 99) < 8) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
            pll_locked = ($urandom_range(0, 3) != 0);
            len = pll_locked ? $urandom_range(1, 200) : $urandom_range(1, 8);
            repeat (len) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_powerup_seq.md
SDRAM_POWERUP_SEQ -- requirements
Module: sdram_powerup_seq

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  CLK_MHZ 100 SDRAM clock frequency, MHz
  PWRUP_US 200 power-up wait, microseconds
  LOCK_STABLE 1024 cycles pll_locked must stay high before sequence starts
  T_RP 3 precharge-to-command cycles
  T_RFC 7 refresh-to-command cycles
  T_MRD 2 load-mode-to-ready cycles
  N_REFRESH 2 auto-refresh commands issued
  MODE_REG 13'h0030 mode register value, CL3, burst 1, sequential
REQ-002 Ports, one per line: name, direction, width, meaning:
  clk input 1 100 MHz PLL clock, sole clock
  rst input 1 synchronous active-high reset
  pll_locked input 1 PLL lock, asynchronous to clk
  sdram_cke output 1 clock enable
  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n output 1 each command pins
  sdram_ba output 2 bank address
  sdram_addr output 13 address bus
  init_done output 1 initialization complete
  sys_rst output 1 downstream reset, active-high
REQ-003 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 pll_locked SHALL pass a 2-FF synchronizer; the synchronized level drives all logic (2-cycle input latency).
REQ-005 The block SHALL assert the internal lock_ok signal only after synchronized lock has been high for LOCK_STABLE consecutive cycles. Any low cycle SHALL clear the stability counter to 0.
REQ-006 The FSM states SHALL be WAIT_LOCK, PWRUP, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC, LOAD_MODE, WAIT_MRD and DONE.
REQ-007 WAIT_LOCK SHALL transition to PWRUP on lock_ok. sdram_cke SHALL be 0 in WAIT_LOCK and 1 in every other state.
REQ-008 PWRUP SHALL hold NOP for exactly CLK_MHZ*PWRUP_US cycles (20000 by default) and then go to PRECHARGE.
REQ-009 Each command state SHALL last exactly 1 cycle. The next command SHALL issue exactly T_RP, T_RFC or T_MRD cycles after the previous command cycle, with NOP on the cycles in between.
REQ-010 Command encodings (cs_n, ras_n, cas_n, we_n) SHALL be:
  NOP 0111
  PRECHARGE 0010 with addr[10]=1 (all banks)
  REFRESH 0001
  LOAD_MODE 0000 with addr=MODE_REG and ba=0
  Outside command cycles, addr and ba SHALL be 0.
REQ-011 REFRESH SHALL be issued exactly N_REFRESH times; the refresh counter SHALL be sized $clog2(N_REFRESH+1).
REQ-012 After the last WAIT_MRD cycle the FSM SHALL enter DONE. init_done SHALL go to 1 and sys_rst to 0 on the same edge, and both SHALL stay there while in DONE.
REQ-013 The delay counter width SHALL be $clog2 of the largest delay. Counters SHALL saturate and never wrap.
REQ-014 If lock_ok drops in any state from PWRUP through WAIT_MRD, the FSM SHALL return to WAIT_LOCK next cycle with NOP, cke=0 and counters cleared.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 While rst=1, and on the following edge, the block SHALL present: state WAIT_LOCK, synchronizer and counters 0, cke=0, command NOP, ba=0, addr=0, init_done=0, sys_rst=1.
REQ-017 rst asserted mid-sequence or in DONE SHALL restart the full sequence, including the lock-stability wait.

Configuration
REQ-018 Macro SDRAM_LOCK_WATCH_EN: when defined, loss of lock_ok in DONE SHALL return the FSM to WAIT_LOCK, drop init_done and raise sys_rst on the next cycle. When undefined, DONE SHALL be terminal until rst and lock loss SHALL be ignored.

Structure
REQ-019 Package sdram_pkg SHALL hold:
  the 4-bit command localparams CMD_NOP, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE
  the FSM state enum
  the SDRAM address and bank widths
REQ-020 The synchronizer and stability filter SHALL be the sub-module lock_filter, with inputs clk, rst, async_in and output stable.

Verification
REQ-021 Benches SHALL override PWRUP_US=1, LOCK_STABLE=16 and CLK_MHZ=100, giving a 100-cycle PWRUP.
REQ-022 Directed scenarios:
  S1: lock high from cycle 0 -> PRECHARGE 2+16+100 cycles later; REFRESH at +3 and +10; LOAD_MODE at +17 with addr=0x030; init_done at +19.
  S2: lock toggles low every 10 cycles -> FSM stays in WAIT_LOCK, cke=0, init_done=0.
  S3: lock drops during WAIT_RFC -> return to WAIT_LOCK; full sequence repeats, with exactly 2 REFRESH commands after re-lock.
  S4: rst pulsed 1 cycle in DONE -> init_done=0, sys_rst=1; sequence repeats identically to S1.
  S5: SDRAM_LOCK_WATCH_EN defined, lock drop in DONE -> init_done=0 within 3 cycles; undefined -> init_done stays 1.
  S6: every cycle -> command bus shows only the four legal encodings; no command is issued while cke=0.
